sr_pq_gen: RTL and testbench
============================

# sr_pq_gen

Parametrised shift-register priority queue, the next generation of the single-cycle PQ in the hw_pq collection. It keeps up to DEPTH key/value entries sorted in a linear array of compare-and-shift stages, exposes the best entry at the head, and accepts one push, one pop, or one simultaneous push+pop (replace) per cycle. Each entry carries an explicit valid bit, so the full key range is usable. Ordering is selectable between min-first and max-first, and equal keys leave in arrival order. It sits between a producer and a consumer on valid/ready handshakes and reports occupancy.

## Interface
- KEY_W, 16: key width in bits.
- VAL_W, 16: value width in bits.
- DEPTH, 8: number of storage stages; must be ≥ 2.
- MAX_FIRST, 0: 0 puts the smallest key at the head; 1 puts the largest key at the head.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer offers in_key/in_val.
- in_ready  out  1  queue can accept a push this cycle.
- in_key  in  KEY_W  key to insert.
- in_val  in  VAL_W  value to insert.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_key  out  KEY_W  head key.
- out_val  out  VAL_W  head value.
- count  out  CNT_W  number of valid entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- Storage: stages 0..DEPTH-1, each holding {valid, key, val}. Valid entries are contiguous from stage 0 and sorted by priority.
- Priority: "a beats b" means a < b when MAX_FIRST=0 and a > b when MAX_FIRST=1, comparing unsigned keys.
- Equal keys: FIFO order. A new entry goes after every existing entry with an equal key.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = !full | (out_ready & out_valid). This is a combinational path from out_ready to in_ready.
- out_valid = stage0.valid. out_key and out_val come straight from stage 0 registers, with no comparator in the output path.
- Push only: each stage i compares in_key with its own entry and with stage i-1's entry.
  - It keeps its entry, loads the new entry, or loads stage i-1's entry.
  - Net effect: the new entry lands in its sorted slot; every entry below that slot shifts one stage toward DEPTH-1.
- Pop only: stage i loads stage i+1. Stage DEPTH-1 becomes invalid.
- Push+pop (replace): the head is removed and the new entry is inserted among the remaining entries in the same cycle, using the same rules.
  - If the new entry beats stage 1's entry, or stage 1 is invalid, it lands in stage 0.
  - count is unchanged.
- Push+pop while empty cannot occur, because pop needs out_valid.
- Push while full is only possible together with a pop (replace), so no entry is ever dropped.
- count: +1 on push only, −1 on pop only, unchanged on replace or idle.
- Stages with invalid entries hold their key/val bits unchanged. Their contents are don't-care and must never reach the outputs while out_valid=0.

## Timing
- Reset (rst_n low, asynchronous): all valid bits are 0 and count=0.
  - Outputs: out_valid=0, empty=1, full=0, in_ready=1.
  - out_key and out_val are 0.
- Release is synchronous to clk. The first push is accepted on the first rising edge with rst_n high.
- Push latency: one cycle. An entry accepted at edge N is visible at the head after edge N if it is the best entry.
- Pop latency: one cycle. The next-best entry is at the head after the popping edge.
- Throughput: one operation per cycle indefinitely, including back-to-back replaces while full.
- full, empty and count are registered-derived and change only on clk edges.
- Reset asserted mid-operation: all entries are discarded at once. No partial shift may be visible after reset.

## Test plan
- Reset, then push keys 5, 2, 9, 2(val=B) after 2(val=A), MAX_FIRST=0. Pop 4 times → head order 2A, 2B, 5, 9; count 4→0; empty=1 after the last pop.
- DEPTH=8: push 8 keys → full=1 and in_ready=0 while out_ready=0. Push 0x0001 with out_ready=1 → head 0x0001 replaces the old head; count stays 8.
- Replace: queue {3, 7}, push 5 with pop → head 5 next cycle, then 7; count stays 2.
- MAX_FIRST=1, KEY_W=16: push 0x0000, 0xFFFF, 0x8000 → pops give 0xFFFF, 0x8000, 0x0000. Confirms the all-ones key is a legal entry.
- Assert rst_n low for 1 ns between edges with 4 entries held → out_valid=0, count=0 immediately. The first push after release appears at the head the next cycle.
- Random push/pop/replace for 10k cycles against a sorted-list model → head, count, full and empty match every cycle; no entry is lost or duplicated.

Source files
------------

// File: rtl/sr_pq_gen_if.sv
// Producer/consumer handshake bundle for the shift-register priority queue.
// The queue is the slave; whoever drives pushes and pops is the master.
interface sr_pq_gen_if #(
    parameter int KEY_W = 16,
    parameter int VAL_W = 16,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_key;
    logic [VAL_W-1:0] in_val;
    logic             out_valid;
    logic             out_ready;
    logic [KEY_W-1:0] out_key;
    logic [VAL_W-1:0] out_val;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport slave (
        input  in_valid, in_key, in_val, out_ready,
        output in_ready, out_valid, out_key, out_val, count, full, empty
    );

    modport master (
        output in_valid, in_key, in_val, out_ready,
        input  in_ready, out_valid, out_key, out_val, count, full, empty
    );
endinterface

// File: rtl/sr_pq_gen.sv
// Shift-register priority queue: DEPTH sorted stages, best entry always in
// stage 0. One push, pop or replace (push+pop) per cycle. Equal keys keep
// arrival order because a new entry only goes ahead of entries it strictly
// beats.
module sr_pq_gen #(
    parameter int KEY_W     = 16,
    parameter int VAL_W     = 16,
    parameter int DEPTH     = 8,
    parameter int MAX_FIRST = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    sr_pq_gen_if.slave   pq
);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][KEY_W-1:0] r_key;
    logic [DEPTH-1:0][VAL_W-1:0] r_val;
    logic [CNT_W-1:0]            r_cnt;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;

    // w_ins[i]: the new entry belongs at or ahead of stage i
    logic [DEPTH-1:0]            w_ins;
    logic [DEPTH-1:0]            w_ins_up;
    logic [DEPTH-1:0]            w_ins_dn;
    logic [DEPTH-1:0]            w_up_vld;
    logic [DEPTH-1:0][KEY_W-1:0] w_up_key;
    logic [DEPTH-1:0][VAL_W-1:0] w_up_val;
    logic [DEPTH-1:0]            w_dn_vld;
    logic [DEPTH-1:0][KEY_W-1:0] w_dn_key;
    logic [DEPTH-1:0][VAL_W-1:0] w_dn_val;

    logic [DEPTH-1:0]            w_nv;
    logic [DEPTH-1:0][KEY_W-1:0] w_nk;
    logic [DEPTH-1:0][VAL_W-1:0] w_nd;

    function automatic logic beats(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        return (MAX_FIRST != 0) ? (a > b) : (a < b);
    endfunction

    assign w_full       = (r_cnt == CNT_W'(DEPTH));
    assign w_pop        = pq.out_valid & pq.out_ready;
    assign w_push       = pq.in_valid & pq.in_ready;

    assign pq.in_ready  = ~w_full | w_pop;
    assign pq.out_valid = r_vld[0];
    // Stale bits of an emptied head never leak out
    assign pq.out_key   = r_vld[0] ? r_key[0] : '0;
    assign pq.out_val   = r_vld[0] ? r_val[0] : '0;
    assign pq.count     = r_cnt;
    assign pq.full      = w_full;
    assign pq.empty     = (r_cnt == '0);

    // Per-stage compare plus views of the neighbours above and below
    for (genvar g = 0; g < DEPTH; g++) begin : g_nb
        assign w_ins[g] = ~r_vld[g] | beats(pq.in_key, r_key[g]);
        if (g == 0) begin : g_top
            assign w_ins_up[g] = 1'b0;
            assign w_up_vld[g] = 1'b0;
            assign w_up_key[g] = r_key[g];
            assign w_up_val[g] = r_val[g];
        end else begin : g_mid_up
            assign w_ins_up[g] = w_ins[g-1];
            assign w_up_vld[g] = r_vld[g-1];
            assign w_up_key[g] = r_key[g-1];
            assign w_up_val[g] = r_val[g-1];
        end
        if (g == DEPTH - 1) begin : g_bot
            assign w_ins_dn[g] = 1'b1;
            assign w_dn_vld[g] = 1'b0;
            assign w_dn_key[g] = r_key[g];
            assign w_dn_val[g] = r_val[g];
        end else begin : g_mid_dn
            assign w_ins_dn[g] = w_ins[g+1];
            assign w_dn_vld[g] = r_vld[g+1];
            assign w_dn_key[g] = r_key[g+1];
            assign w_dn_val[g] = r_val[g+1];
        end
    end

    // Next contents of every stage: keep, take the new entry, or shift
    always_comb begin
        w_nv = r_vld;
        w_nk = r_key;
        w_nd = r_val;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_push && !w_pop) begin
                if (w_ins[i] && !w_ins_up[i]) begin
                    w_nv[i] = 1'b1;
                    w_nk[i] = pq.in_key;
                    w_nd[i] = pq.in_val;
                end else if (w_ins[i]) begin
                    w_nv[i] = w_up_vld[i];
                    w_nk[i] = w_up_key[i];
                    w_nd[i] = w_up_val[i];
                end
            end else if (w_push && w_pop) begin
                // Head leaves; the survivors are stages 1.., and stage i's
                // own compare decides whether the new entry sits above it.
                if (w_ins_dn[i] && (i == 0 || !w_ins[i])) begin
                    w_nv[i] = 1'b1;
                    w_nk[i] = pq.in_key;
                    w_nd[i] = pq.in_val;
                end else if (!w_ins_dn[i]) begin
                    w_nv[i] = w_dn_vld[i];
                    w_nk[i] = w_dn_key[i];
                    w_nd[i] = w_dn_val[i];
                end
            end else if (w_pop) begin
                w_nv[i] = w_dn_vld[i];
                w_nk[i] = w_dn_key[i];
                w_nd[i] = w_dn_val[i];
            end
        end
    end

    // Stage registers and occupancy; invalid stages leave key/val untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_key <= '0;
            r_val <= '0;
            r_cnt <= '0;
        end else begin
            r_vld <= w_nv;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_nv[i]) begin
                    r_key[i] <= w_nk[i];
                    r_val[i] <= w_nd[i];
                end
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_pq_gen.sv
// Bench for sr_pq_gen: a min-first and a max-first instance share stimulus,
// each tracked by its own sorted-list reference model.
module tb_sr_pq_gen;
    localparam int KW = 16;
    localparam int VW = 16;
    localparam int D  = 8;
    localparam int CW = 4;

    logic clk;
    logic rst_n;

    sr_pq_gen_if #(.KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) if0 ();
    sr_pq_gen_if #(.KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) if1 ();

    sr_pq_gen #(.KEY_W(KW), .VAL_W(VW), .DEPTH(D), .MAX_FIRST(0), .CNT_W(CW)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .pq    (if0.slave)
    );

    sr_pq_gen #(.KEY_W(KW), .VAL_W(VW), .DEPTH(D), .MAX_FIRST(1), .CNT_W(CW)) u_max (
        .clk   (clk),
        .rst_n (rst_n),
        .pq    (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [KW-1:0] m_key [2][D];
    logic [VW-1:0] m_val [2][D];
    int            m_n   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_n[0] = 0;
        m_n[1] = 0;
    endfunction

    function automatic bit model_ready(input int q, input bit ordy);
        return (m_n[q] < D) || (ordy && m_n[q] > 0);
    endfunction

    // Sorted list: pop removes the front, push inserts ahead of the first
    // entry the new key strictly beats (so equal keys stay in arrival order).
    function automatic void model_step(input int q, input bit v, input logic [KW-1:0] k,
                                       input logic [VW-1:0] d, input bit ordy);
        bit pop;
        bit push;
        int pos;
        pop  = ordy && (m_n[q] > 0);
        push = v && model_ready(q, ordy);
        if (pop) begin
            for (int j = 0; j < D - 1; j++) begin
                m_key[q][j] = m_key[q][j+1];
                m_val[q][j] = m_val[q][j+1];
            end
            m_n[q]--;
        end
        if (push) begin
            pos = m_n[q];
            for (int j = m_n[q] - 1; j >= 0; j--) begin
                if ((q == 1) ? (k > m_key[q][j]) : (k < m_key[q][j])) pos = j;
            end
            for (int j = m_n[q]; j > pos; j--) begin
                m_key[q][j] = m_key[q][j-1];
                m_val[q][j] = m_val[q][j-1];
            end
            m_key[q][pos] = k;
            m_val[q][pos] = d;
            m_n[q]++;
        end
    endfunction

    task automatic check_q(input int q, input logic ov, input logic [KW-1:0] ok,
                           input logic [VW-1:0] od, input logic [CW-1:0] cnt,
                           input logic fl, input logic em);
        chk($sformatf("q%0d_out_valid", q), ov, m_n[q] > 0);
        if (m_n[q] > 0) begin
            chk($sformatf("q%0d_out_key", q), ok, m_key[q][0]);
            chk($sformatf("q%0d_out_val", q), od, m_val[q][0]);
        end
        chk($sformatf("q%0d_count", q), cnt, m_n[q]);
        chk($sformatf("q%0d_full", q), fl, m_n[q] == D);
        chk($sformatf("q%0d_empty", q), em, m_n[q] == 0);
    endtask

    task automatic check_all();
        check_q(0, if0.out_valid, if0.out_key, if0.out_val, if0.count, if0.full, if0.empty);
        check_q(1, if1.out_valid, if1.out_key, if1.out_val, if1.count, if1.full, if1.empty);
    endtask

    task automatic drive(input bit v, input logic [KW-1:0] k, input logic [VW-1:0] d, input bit ordy);
        if0.in_valid = v; if0.in_key = k; if0.in_val = d; if0.out_ready = ordy;
        if1.in_valid = v; if1.in_key = k; if1.in_val = d; if1.out_ready = ordy;
    endtask

    // One clock of stimulus: drive, check in_ready, clock, update models, check
    task automatic step(input bit v, input logic [KW-1:0] k, input logic [VW-1:0] d, input bit ordy);
        drive(v, k, d, ordy);
        #1;
        chk("q0_in_ready", if0.in_ready, model_ready(0, ordy));
        chk("q1_in_ready", if1.in_ready, model_ready(1, ordy));
        @(posedge clk);
        model_step(0, v, k, d, ordy);
        model_step(1, v, k, d, ordy);
        #1;
        check_all();
    endtask

    task automatic drain();
        for (int j = 0; j < D + 1; j++) step(1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [KW-1:0] t1_k [4];
    logic [VW-1:0] t1_v [4];
    logic [KW-1:0] t4_k [3];
    int pv, pr;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        model_reset();
        #1;
        chk("rst_out_key0", if0.out_key, 0);
        chk("rst_out_val0", if0.out_val, 0);
        chk("rst_in_ready0", if0.in_ready, 1);
        chk("rst_in_ready1", if1.in_ready, 1);
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Min-first ordering with a tie on key 2
        step(1'b1, 16'd5, 16'h0055, 1'b0);
        step(1'b1, 16'd2, 16'h000A, 1'b0);
        step(1'b1, 16'd9, 16'h0099, 1'b0);
        step(1'b1, 16'd2, 16'h000B, 1'b0);
        t1_k = '{16'd2, 16'd2, 16'd5, 16'd9};
        t1_v = '{16'h000A, 16'h000B, 16'h0055, 16'h0099};
        for (int j = 0; j < 4; j++) begin
            chk("t1_head_key", if0.out_key, t1_k[j]);
            chk("t1_head_val", if0.out_val, t1_v[j]);
            chk("t1_count", if0.count, 4 - j);
            step(1'b0, '0, '0, 1'b1);
        end
        chk("t1_empty", if0.empty, 1);

        // Fill to DEPTH, then replace while full
        for (int j = 0; j < D; j++) step(1'b1, KW'(16'h0010 + j * 3), VW'(j), 1'b0);
        chk("t2_full", if0.full, 1);
        drive(1'b1, 16'h0001, 16'h0077, 1'b0);
        #1;
        chk("t2_in_ready_full", if0.in_ready, 0);
        step(1'b1, 16'h0001, 16'h0077, 1'b1);
        chk("t2_replace_head", if0.out_key, 16'h0001);
        chk("t2_replace_count", if0.count, 8);
        drain();

        // Replace into a two-entry queue
        step(1'b1, 16'd3, 16'h0003, 1'b0);
        step(1'b1, 16'd7, 16'h0007, 1'b0);
        step(1'b1, 16'd5, 16'h0005, 1'b1);
        chk("t3_head5", if0.out_key, 16'd5);
        chk("t3_count2", if0.count, 2);
        step(1'b0, '0, '0, 1'b1);
        chk("t3_head7", if0.out_key, 16'd7);
        drain();

        // Max-first with extreme keys
        step(1'b1, 16'h0000, 16'h0001, 1'b0);
        step(1'b1, 16'hFFFF, 16'h0002, 1'b0);
        step(1'b1, 16'h8000, 16'h0003, 1'b0);
        t4_k = '{16'hFFFF, 16'h8000, 16'h0000};
        for (int j = 0; j < 3; j++) begin
            chk("t4_max_head", if1.out_key, t4_k[j]);
            step(1'b0, '0, '0, 1'b1);
        end
        chk("t4_max_empty", if1.empty, 1);
        drain();

        // Asynchronous reset between edges with entries held
        for (int j = 0; j < 4; j++) step(1'b1, KW'(j * 11 + 1), VW'(j), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_valid0", if0.out_valid, 0);
        chk("t5_rst_count0", if0.count, 0);
        chk("t5_rst_valid1", if1.out_valid, 0);
        chk("t5_rst_count1", if1.count, 0);
        rst_n = 1'b1;
        step(1'b1, 16'h0042, 16'h0042, 1'b0);
        chk("t5_first_push", if0.out_key, 16'h0042);
        drain();

        // Random push/pop/replace
        pv = 50;
        pr = 50;
        for (int c = 0; c < 10000; c++) begin
            if (c % 400 == 0) begin
                pv = $urandom_range(20, 90);
                pr = $urandom_range(10, 80);
            end
            step($urandom_range(0, 99) < pv,
                 ($urandom_range(0, 3) == 0) ? KW'($urandom) : KW'($urandom_range(0, 15)),
                 VW'($urandom),
                 $urandom_range(0, 99) < pr);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
